// File: rtl/axi_lp_ctrl.sv
// AXI low-power interface sequencer: one independent channel FSM per peripheral
// handling idle detection, CSYSREQ/CSYSACK handshake, clock gating and wake-up.

module axi_lp_chan #(
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_DLY   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  lp_en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  input  logic                  wake_req_i,
  input  logic                  cactive_i,
  input  logic                  csysack_i,
  output logic                  csysreq_o,
  output logic                  clk_en_o,
  output logic [1:0]            state_o,
  output logic                  deny_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_REQ  = 2'b01,
    ST_LP   = 2'b10,
    ST_WAKE = 2'b11
  } state_e;

  localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = '1;
  localparam logic [3:0]            WAKE_C   = 4'(WAKE_DLY);

  state_e                state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_q, idle_d;
  logic [3:0]            wake_q, wake_d;
  logic                  csysreq_q, csysreq_d;
  logic                  clken_q, clken_d;
  logic                  deny_q, deny_d;
  logic                  idle_ok;

  assign idle_ok = lp_en_i & ~cactive_i & ~wake_req_i & csysack_i;

  always_comb begin
    state_d   = state_q;
    idle_d    = '0;
    wake_d    = wake_q;
    csysreq_d = csysreq_q;
    clken_d   = 1'b1;
    deny_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        csysreq_d = 1'b1;
        wake_d    = '0;
        // wake_req_i is folded into idle_ok, so it always beats the threshold
        if (idle_ok) begin
          idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_CNT_W'(1);
          if (idle_thresh_i != '0 && idle_q >= idle_thresh_i) begin
            state_d   = ST_REQ;
            csysreq_d = 1'b0;
            idle_d    = '0;
          end
        end
      end
      ST_REQ: begin
        csysreq_d = 1'b0;
        if (!csysack_i) begin
          if (cactive_i) begin
            state_d   = ST_WAKE;
            wake_d    = WAKE_C;
            csysreq_d = 1'b1;
            deny_d    = 1'b1;
          end else begin
            state_d = ST_LP;
          end
        end
      end
      ST_LP: begin
        csysreq_d = 1'b0;
        if (wake_req_i || cactive_i || !lp_en_i) begin
          state_d = ST_WAKE;
          wake_d  = '0;
        end else begin
          clken_d = 1'b0;
        end
      end
      ST_WAKE: begin
        // CSYSREQ rises after ClkEn has been high for WAKE_DLY cycles
        if (csysreq_q && csysack_i) begin
          state_d   = ST_RUN;
          wake_d    = '0;
          csysreq_d = 1'b1;
        end else if (wake_q >= WAKE_C - 4'd1) begin
          wake_d    = WAKE_C;
          csysreq_d = 1'b1;
        end else begin
          wake_d    = wake_q + 4'd1;
          csysreq_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_RUN;
        csysreq_d = 1'b1;
        wake_d    = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_RUN;
      idle_q    <= '0;
      wake_q    <= '0;
      csysreq_q <= 1'b1;
      clken_q   <= 1'b1;
      deny_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      wake_q    <= wake_d;
      csysreq_q <= csysreq_d;
      clken_q   <= clken_d;
      deny_q    <= deny_d;
    end
  end

  assign csysreq_o = csysreq_q;
  assign clk_en_o  = clken_q;
  assign state_o   = state_q;
  assign deny_o    = deny_q;

endmodule

module axi_lp_ctrl #(
  parameter int NUM_PERIPH = 4,
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_DLY   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [NUM_PERIPH-1:0]   LpEnable,
  input  logic [IDLE_CNT_W-1:0]   IdleThresh,
  input  logic [NUM_PERIPH-1:0]   WakeReq,
  input  logic [NUM_PERIPH-1:0]   CACTIVE,
  input  logic [NUM_PERIPH-1:0]   CSYSACK,
  output logic [NUM_PERIPH-1:0]   CSYSREQ,
  output logic [NUM_PERIPH-1:0]   ClkEn,
  output logic [2*NUM_PERIPH-1:0] LpState,
  output logic [NUM_PERIPH-1:0]   DenyPulse
);

  for (genvar g = 0; g < NUM_PERIPH; g++) begin : g_chan
    axi_lp_chan #(
      .IDLE_CNT_W (IDLE_CNT_W),
      .WAKE_DLY   (WAKE_DLY)
    ) u_chan (
      .ACLK          (ACLK),
      .ARESETn       (ARESETn),
      .lp_en_i       (LpEnable[g]),
      .idle_thresh_i (IdleThresh),
      .wake_req_i    (WakeReq[g]),
      .cactive_i     (CACTIVE[g]),
      .csysack_i     (CSYSACK[g]),
      .csysreq_o     (CSYSREQ[g]),
      .clk_en_o      (ClkEn[g]),
      .state_o       (LpState[2*g +: 2]),
      .deny_o        (DenyPulse[g])
    );
  end

endmodule
